cl_acc: RTL and testbench
=========================

CL_ACC -- requirements
Module: cl_acc

Interface
REQ-001 Parameter W SHALL be: default 8, operand/result width in bits (W >= 1).
REQ-002 Parameter CW SHALL be: default 8, width of the transaction counter.
REQ-003 Port clk SHALL be: input, 1, single clock; all state updates on its rising edge.
REQ-004 Port reset_n SHALL be: input, 1, synchronous, active-low reset.
REQ-005 Port in_valid SHALL be: input, 1, operands/opcode valid.
REQ-006 Port in_ready SHALL be: output, 1, block can accept a transaction.
REQ-007 Port a SHALL be: input, W, operand A.
REQ-008 Port b SHALL be: input, W, operand B.
REQ-009 Port s SHALL be: input, 2, opcode (00 AND, 01 OR, 10 XOR, 11 NOT A).
REQ-010 Port acc_sel SHALL be: input, 1, use accumulator instead of a as operand A.
REQ-011 Port acc_clr SHALL be: input, 1, synchronous accumulator clear.
REQ-012 Port out_valid SHALL be: output, 1, result valid.
REQ-013 Port out_ready SHALL be: input, 1, consumer accepts result.
REQ-014 Port out SHALL be: output, W, registered result.
REQ-015 Port cnt SHALL be: output, CW, count of accepted transactions.

Function
REQ-016 Operation SHALL be bitwise per s: 00 A&B, 01 A|B, 10 A^B, 11 ~A, where A = acc_sel ? acc : a.
REQ-017 Handshake SHALL be: in_ready = reset_n && (!out_valid || out_ready); a transaction is accepted when in_valid && in_ready.
REQ-018 Latency SHALL be one cycle: on acceptance, out and acc load the result and out_valid = 1 at the next edge.
REQ-019 Output state machine SHALL have states EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on out_ready && !accept.
  - FULL -> FULL on accept, including simultaneous drain and accept, for full throughput.
REQ-020 While FULL and out_ready=0, out SHALL hold stable and no input SHALL be accepted.
REQ-021 acc_clr SHALL set acc to 0 at the next edge and has priority over the accept load. An accepted operation in the same cycle SHALL use the pre-clear acc and still produce its result on out.
REQ-022 acc_clr SHALL NOT affect out, out_valid or cnt.
REQ-023 cnt SHALL increment by 1 on each accept and wrap from 2^CW-1 to 0.
REQ-024 Inputs SHALL be ignored when in_valid=0; the acc_sel and s values of non-accepted cycles have no effect.

Reset
REQ-025 While reset_n=0 at a rising edge: out = 0, acc = 0, out_valid = 0, cnt = 0, and in_ready = 0.
REQ-026 Reset asserted mid-transaction SHALL discard any pending result, with no output handshake completed.
REQ-027 The first accept SHALL be possible in the first cycle after reset_n returns high.

Configuration
REQ-028 Macro CL_ACC_FLAGS_EN, when defined, SHALL add two output ports, each registered and loaded together with out, reset to 0:
  - zf (1): result == 0.
  - pf (1): XOR-reduction of the result.
REQ-029 Without CL_ACC_FLAGS_EN, the zf/pf ports and their registers SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package cl_pkg SHALL hold the opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOT=2'b11 and the default width W_DEF=8.
REQ-031 The combinational W-bit bitwise logic slice SHALL be a sub-module cl_n (inputs A, B, s; output W-bit result), instantiated once.
REQ-032 The handshake, acc and cnt registers SHALL reside in cl_acc.

Verification (W=8, CW=8)
REQ-033 Basic AND: after reset, apply a=F0, b=3C, s=00, in_valid=1 for one cycle, out_ready=1.
  - Next cycle: out_valid=1, out=30, acc=30, cnt=1.
REQ-034 Backpressure: out_ready=0, offer a=FF, b=0F, s=00, then a=00, b=AA, s=01.
  - out=0F is held and in_ready=0.
  - Raise out_ready: second result out=AA follows one cycle after acceptance.
REQ-035 Accumulate: with acc=30, apply acc_sel=1, b=0F, s=10 -> out=3F.
  - Then acc_sel=1, s=11 -> out=C0.
REQ-036 Clear collision: with acc=3F, accept acc_sel=1, b=FF, s=00 with acc_clr=1.
  - out=3F and acc=00.
  - Next acc_sel=1, s=01, b=00 -> out=00.
REQ-037 Counter and reset: after 256 accepts cnt=00; reset_n=0 in FULL -> out_valid=0, out=00, acc=00, cnt=00 next edge.
REQ-038 Flags (macro defined): result 00 -> zf=1, pf=0; result 07 -> zf=0, pf=1.

Source files
------------

// File: rtl/cl_acc_pkg.sv
// cl_pkg: shared constants and types for the cl_acc accumulator block.
//   OP_*   : opcode encodings for the bitwise logic slice
//   W_DEF  : default operand/result width
//   ostate_e: output-register state (EMPTY / FULL)
// Optional feature macro used by this block: CL_ACC_FLAGS_EN.
package cl_pkg;
    localparam int W_DEF = 8;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ostate_e;
endpackage

// File: rtl/cl_acc_if.sv
// cl_acc_if: request/response bundle for cl_acc.
//   in_valid/in_ready : input handshake; a, b, s, acc_sel, acc_clr ride with it
//   out_valid/out_ready: output handshake; out carries the registered result
//   cnt               : count of accepted transactions
//   zf, pf            : zero / parity flags, present only with CL_ACC_FLAGS_EN
// Modports: master = producer/consumer side, slave = cl_acc.
interface cl_acc_if
    import cl_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    s;
    logic          acc_sel;
    logic          acc_clr;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out;
    logic [CW-1:0] cnt;
`ifdef CL_ACC_FLAGS_EN
    logic          zf;
    logic          pf;
`endif

    modport master (
        output in_valid, a, b, s, acc_sel, acc_clr, out_ready,
        input  in_ready, out_valid, out, cnt
`ifdef CL_ACC_FLAGS_EN
        , input zf, pf
`endif
    );

    modport slave (
        input  in_valid, a, b, s, acc_sel, acc_clr, out_ready,
        output in_ready, out_valid, out, cnt
`ifdef CL_ACC_FLAGS_EN
        , output zf, pf
`endif
    );
endinterface

// File: rtl/cl_acc_n.sv
// cl_n: combinational W-bit bitwise logic slice.
//   A, B   : operands
//   s      : opcode (AND, OR, XOR, NOT A)
//   result : bitwise result
module cl_n
    import cl_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [1:0]   s,
    output logic [W-1:0] result
);
    always_comb begin
        result = '0;
        case (s)
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_XOR:  result = A ^ B;
            default: result = ~A;   // OP_NOT
        endcase
    end
endmodule

// File: rtl/cl_acc.sv
// cl_acc: bitwise logic unit with accumulator and one-deep output register.
//   clk     : single clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : cl_acc_if.slave (input/output handshakes, operands, result, cnt)
// Optional: define CL_ACC_FLAGS_EN to add registered zf/pf result flags.
module cl_acc
    import cl_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = 8
) (
    input  logic    clk,
    input  logic    reset_n,
    cl_acc_if.slave bus
);
    ostate_e       state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  op_a, res;
    logic          in_ready, accept;

    // Ready while in reset is forced low so nothing is accepted during reset.
    assign in_ready = reset_n && ((state_q == ST_EMPTY) || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign op_a     = bus.acc_sel ? acc_q : bus.a;

    cl_n #(.W(W)) u_n (
        .A      (op_a),
        .B      (bus.b),
        .s      (bus.s),
        .result (res)
    );

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (bus.out_ready && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        if (accept) begin
            out_d = res;
            acc_d = res;
            cnt_d = cnt_q + 1'b1;
        end
        // Clear wins over the load; the same-cycle op already used the old acc.
        if (bus.acc_clr) acc_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            acc_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CL_ACC_FLAGS_EN
    logic zf_q, pf_q;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            zf_q <= 1'b0;
            pf_q <= 1'b0;
        end else if (accept) begin
            zf_q <= ~|res;
            pf_q <= ^res;
        end
    end
    assign bus.zf = zf_q;
    assign bus.pf = pf_q;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out       = out_q;
    assign bus.cnt       = cnt_q;
endmodule

// File: tb/tb_cl_acc.sv
// tb_cl_acc: directed self-checking bench for cl_acc (W=8, CW=8).
module tb_cl_acc;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cl_acc_if #(.W(8), .CW(8)) bus ();
    cl_acc #(.W(8), .CW(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    // Inputs change 1 time unit after the rising edge; outputs read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.a = 8'h00; bus.b = 8'h00; bus.s = 2'b00;
        bus.acc_sel = 0; bus.acc_clr = 0; bus.out_ready = 0;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        step(); step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_ovalid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out !== 8'h00) begin errors++; $display("FAIL rst_out got %h exp 00", bus.out); end
        checks++; if (bus.cnt !== 8'h00) begin errors++; $display("FAIL rst_cnt got %h exp 00", bus.cnt); end
        checks++; if (dut.acc_q !== 8'h00) begin errors++; $display("FAIL rst_acc got %h exp 00", dut.acc_q); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_iready got %b exp 0", bus.in_ready); end
        reset_n = 1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_iready got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_basic_and();
        bus.in_valid = 1; bus.a = 8'hF0; bus.b = 8'h3C; bus.s = 2'b00; bus.out_ready = 1;
        step();
        bus.in_valid = 0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL and_ovalid got %b exp 1", bus.out_valid); end
        checks++; if (bus.out !== 8'h30) begin errors++; $display("FAIL and_out got %h exp 30", bus.out); end
        checks++; if (dut.acc_q !== 8'h30) begin errors++; $display("FAIL and_acc got %h exp 30", dut.acc_q); end
        checks++; if (bus.cnt !== 8'd1) begin errors++; $display("FAIL and_cnt got %h exp 01", bus.cnt); end
    endtask

    // Back-to-back accepts while FULL with out_ready=1 (full throughput).
    task automatic test_accumulate();
        bus.in_valid = 1; bus.acc_sel = 1; bus.a = 8'h55; bus.b = 8'h0F; bus.s = 2'b10;
        step();
        checks++; if (bus.out !== 8'h3F) begin errors++; $display("FAIL accx_out got %h exp 3F", bus.out); end
        bus.s = 2'b11; bus.b = 8'h00;
        step();
        bus.in_valid = 0; bus.acc_sel = 0;
        checks++; if (bus.out !== 8'hC0) begin errors++; $display("FAIL accn_out got %h exp C0", bus.out); end
        checks++; if (dut.acc_q !== 8'hC0) begin errors++; $display("FAIL accn_acc got %h exp C0", dut.acc_q); end
        checks++; if (bus.cnt !== 8'd3) begin errors++; $display("FAIL accn_cnt got %h exp 03", bus.cnt); end
    endtask

    task automatic test_ignore();
        bus.in_valid = 0; bus.acc_sel = 1; bus.s = 2'b11; bus.a = 8'h12; bus.b = 8'h34; bus.out_ready = 1;
        step(); step();
        bus.acc_sel = 0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ign_ovalid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out !== 8'hC0) begin errors++; $display("FAIL ign_out got %h exp C0", bus.out); end
        checks++; if (dut.acc_q !== 8'hC0) begin errors++; $display("FAIL ign_acc got %h exp C0", dut.acc_q); end
        checks++; if (bus.cnt !== 8'd3) begin errors++; $display("FAIL ign_cnt got %h exp 03", bus.cnt); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 0;
        bus.in_valid = 1; bus.a = 8'hFF; bus.b = 8'h0F; bus.s = 2'b00;
        step();
        bus.a = 8'h00; bus.b = 8'hAA; bus.s = 2'b01;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_iready got %b exp 0", bus.in_ready); end
        step(); step();
        checks++; if (bus.out !== 8'h0F) begin errors++; $display("FAIL bp_hold_out got %h exp 0F", bus.out); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_ovalid got %b exp 1", bus.out_valid); end
        checks++; if (bus.cnt !== 8'd4) begin errors++; $display("FAIL bp_cnt got %h exp 04", bus.cnt); end
        bus.out_ready = 1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", bus.in_ready); end
        step();
        bus.in_valid = 0;
        checks++; if (bus.out !== 8'hAA) begin errors++; $display("FAIL bp_out2 got %h exp AA", bus.out); end
        checks++; if (bus.cnt !== 8'd5) begin errors++; $display("FAIL bp_cnt2 got %h exp 05", bus.cnt); end
    endtask

    task automatic test_clear();
        bus.out_ready = 1;
        bus.in_valid = 1; bus.acc_sel = 0; bus.a = 8'h3F; bus.b = 8'h00; bus.s = 2'b01;
        step();
        checks++; if (dut.acc_q !== 8'h3F) begin errors++; $display("FAIL clr_setup got %h exp 3F", dut.acc_q); end
        bus.acc_sel = 1; bus.b = 8'hFF; bus.s = 2'b00; bus.acc_clr = 1;
        step();
        bus.acc_clr = 0;
        checks++; if (bus.out !== 8'h3F) begin errors++; $display("FAIL clr_out got %h exp 3F", bus.out); end
        checks++; if (dut.acc_q !== 8'h00) begin errors++; $display("FAIL clr_acc got %h exp 00", dut.acc_q); end
        checks++; if (bus.cnt !== 8'd7) begin errors++; $display("FAIL clr_cnt got %h exp 07", bus.cnt); end
        bus.s = 2'b01; bus.b = 8'h00;
        step();
        checks++; if (bus.out !== 8'h00) begin errors++; $display("FAIL clr_next got %h exp 00", bus.out); end
        bus.acc_sel = 0; bus.a = 8'h5A; bus.b = 8'hFF; bus.s = 2'b00;
        step();
        // Clear alone must leave the output side untouched.
        bus.in_valid = 0; bus.out_ready = 0; bus.acc_clr = 1;
        step();
        bus.acc_clr = 0;
        checks++; if (dut.acc_q !== 8'h00) begin errors++; $display("FAIL clr_only_acc got %h exp 00", dut.acc_q); end
        checks++; if (bus.out !== 8'h5A) begin errors++; $display("FAIL clr_only_out got %h exp 5A", bus.out); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL clr_only_ovalid got %b exp 1", bus.out_valid); end
        checks++; if (bus.cnt !== 8'd9) begin errors++; $display("FAIL clr_only_cnt got %h exp 09", bus.cnt); end
    endtask

    task automatic test_cnt_wrap();
        idle();
        reset_n = 0;
        step();
        reset_n = 1;
        bus.out_ready = 1; bus.in_valid = 1; bus.a = 8'h5A; bus.b = 8'hFF; bus.s = 2'b00;
        repeat (255) step();
        checks++; if (bus.cnt !== 8'hFF) begin errors++; $display("FAIL cnt_255 got %h exp FF", bus.cnt); end
        step();
        checks++; if (bus.cnt !== 8'h00) begin errors++; $display("FAIL cnt_wrap got %h exp 00", bus.cnt); end
        checks++; if (bus.out !== 8'h5A) begin errors++; $display("FAIL cnt_out got %h exp 5A", bus.out); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 0;
        step();
        reset_n = 0;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_iready got %b exp 0", bus.in_ready); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_ovalid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out !== 8'h00) begin errors++; $display("FAIL mid_out got %h exp 00", bus.out); end
        checks++; if (dut.acc_q !== 8'h00) begin errors++; $display("FAIL mid_acc got %h exp 00", dut.acc_q); end
        checks++; if (bus.cnt !== 8'h00) begin errors++; $display("FAIL mid_cnt got %h exp 00", bus.cnt); end
        idle();
        reset_n = 1;
    endtask

`ifdef CL_ACC_FLAGS_EN
    task automatic test_flags();
        checks++; if ({bus.zf, bus.pf} !== 2'b00) begin errors++; $display("FAIL flg_rst got %b exp 00", {bus.zf, bus.pf}); end
        bus.out_ready = 1; bus.in_valid = 1; bus.a = 8'h00; bus.b = 8'h00; bus.s = 2'b00;
        step();
        checks++; if ({bus.zf, bus.pf} !== 2'b10) begin errors++; $display("FAIL flg_zero got %b exp 10", {bus.zf, bus.pf}); end
        bus.a = 8'h07; bus.b = 8'h07;
        step();
        bus.in_valid = 0;
        checks++; if ({bus.zf, bus.pf} !== 2'b01) begin errors++; $display("FAIL flg_07 got %b exp 01", {bus.zf, bus.pf}); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_and();
        test_accumulate();
        test_ignore();
        test_backpressure();
        test_clear();
        test_cnt_wrap();
        test_reset_mid();
`ifdef CL_ACC_FLAGS_EN
        test_flags();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
